// File: rtl/rr_arbiter8.sv
//------------------------------------------------------------------------------
// rr_arbiter8 : 8-way round-robin arbiter, registered one-hot grant + index,
//               grant held until req drops or the hold timeout expires.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module rr_arbiter8 #(
   parameter int N_REQ    = 8,
   parameter int IDX_W    = 3,
   parameter int MAX_HOLD = 16
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [N_REQ-1:0] req,
   output logic [N_REQ-1:0] gnt,
   output logic [IDX_W-1:0] gnt_idx,
   output logic             gnt_valid,
   output logic             timeout_evt
);

   localparam int c_hold_w = (MAX_HOLD > 1) ? $clog2(MAX_HOLD) : 1;
   localparam logic [c_hold_w-1:0] c_hold_last = c_hold_w'((MAX_HOLD > 0) ? MAX_HOLD - 1 : 0);

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_GRANT = 2'd1,
      ST_TURN  = 2'd2
   } state_t;

   state_t              r_state, w_state_nxt;
   logic [N_REQ-1:0]    r_gnt, w_gnt_nxt;
   logic [IDX_W-1:0]    r_gnt_idx, w_idx_nxt;
   logic [IDX_W-1:0]    r_ptr, w_ptr_nxt;
   logic [c_hold_w-1:0] r_hold_cnt, w_hold_nxt;
   logic                r_timeout_evt, w_evt_nxt;

   logic                w_found;
   logic [IDX_W-1:0]    w_win;
   logic [IDX_W-1:0]    w_cand;
   logic                w_hold_expire;

   // First requester at or after the rotating pointer, wrapping mod N_REQ.
   always_comb begin
      w_found = 1'b0;
      w_win   = '0;
      w_cand  = '0;
      for (int k = 0; k < N_REQ; k++) begin
         w_cand = r_ptr + IDX_W'(k);
         if (!w_found && req[w_cand]) begin
            w_found = 1'b1;
            w_win   = w_cand;
         end
      end
   end

   assign w_hold_expire = (MAX_HOLD != 0) && (r_hold_cnt == c_hold_last);

   always_comb begin
      w_state_nxt = r_state;
      w_gnt_nxt   = r_gnt;
      w_idx_nxt   = r_gnt_idx;
      w_ptr_nxt   = r_ptr;
      w_hold_nxt  = r_hold_cnt;
      w_evt_nxt   = 1'b0;
      case (r_state)
         ST_IDLE: begin
            if (w_found) begin
               w_state_nxt = ST_GRANT;
               w_gnt_nxt   = N_REQ'(1) << w_win;
               w_idx_nxt   = w_win;
               w_ptr_nxt   = w_win + IDX_W'(1);
               w_hold_nxt  = '0;
            end
         end
         ST_GRANT: begin
            // A dropped request wins over a coincident expiry: normal release.
            if (!req[r_gnt_idx]) begin
               w_state_nxt = ST_TURN;
               w_gnt_nxt   = '0;
               w_idx_nxt   = '0;
            end else if (w_hold_expire) begin
               w_state_nxt = ST_TURN;
               w_gnt_nxt   = '0;
               w_idx_nxt   = '0;
               w_evt_nxt   = 1'b1;
            end else begin
               w_hold_nxt  = r_hold_cnt + c_hold_w'(1);
            end
         end
         ST_TURN: begin
            w_state_nxt = ST_IDLE;
         end
         default: begin
            w_state_nxt = ST_IDLE;
            w_gnt_nxt   = '0;
            w_idx_nxt   = '0;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state       <= ST_IDLE;
         r_gnt         <= '0;
         r_gnt_idx     <= '0;
         r_ptr         <= '0;
         r_hold_cnt    <= '0;
         r_timeout_evt <= 1'b0;
      end else begin
         r_state       <= w_state_nxt;
         r_gnt         <= w_gnt_nxt;
         r_gnt_idx     <= w_idx_nxt;
         r_ptr         <= w_ptr_nxt;
         r_hold_cnt    <= w_hold_nxt;
         r_timeout_evt <= w_evt_nxt;
      end
   end

   assign gnt         = r_gnt;
   assign gnt_idx     = r_gnt_idx;
   assign gnt_valid   = |r_gnt;
   assign timeout_evt = r_timeout_evt;

endmodule

`default_nettype wire

// File: tb/tb_rr_arbiter8.sv
//------------------------------------------------------------------------------
// tb_rr_arbiter8 : directed and randomized bench for rr_arbiter8.
// Revision       : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_rr_arbiter8;

   localparam int MAX_HOLD = 16;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic [7:0] req = 8'h00;
   logic [7:0] gnt;
   logic [2:0] gnt_idx;
   logic       gnt_valid;
   logic       timeout_evt;

   int tests = 0;
   int fails = 0;

   // Reference model: who owns the resource, for how many cycles so far,
   // whether we are in the post-release gap, and the next-favoured requester.
   int m_owner;
   int m_held;
   int m_gap;
   int m_ptr;
   bit m_evt;

   rr_arbiter8 #(.N_REQ(8), .IDX_W(3), .MAX_HOLD(MAX_HOLD)) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .req         (req),
      .gnt         (gnt),
      .gnt_idx     (gnt_idx),
      .gnt_valid   (gnt_valid),
      .timeout_evt (timeout_evt)
   );

   always #5 clk = ~clk;

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish (got running, expected done)");
      $fatal(1, "watchdog expired");
   end

   task automatic model_reset();
      m_owner = -1;
      m_held  = 0;
      m_gap   = 0;
      m_ptr   = 0;
      m_evt   = 1'b0;
   endtask

   task automatic model_step(input logic [7:0] r);
      m_evt = 1'b0;
      if (m_owner >= 0) begin
         if (!r[m_owner]) begin
            m_owner = -1;
            m_gap   = 1;
         end else if (MAX_HOLD != 0 && m_held == MAX_HOLD) begin
            m_owner = -1;
            m_gap   = 1;
            m_evt   = 1'b1;
         end else begin
            m_held++;
         end
      end else if (m_gap > 0) begin
         m_gap--;
      end else if (r != 8'h00) begin
         for (int k = 0; k < 8; k++) begin
            if (m_owner < 0 && r[(m_ptr + k) % 8]) m_owner = (m_ptr + k) % 8;
         end
         m_held = 1;
         m_ptr  = (m_owner + 1) % 8;
      end
   endtask

   task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
      tests++;
      assert (got === exp) else begin
         fails++;
         $error("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic check_model(input string tag);
      logic [7:0] e_gnt;
      logic [2:0] e_idx;
      e_gnt = (m_owner >= 0) ? 8'(1 << m_owner) : 8'h00;
      e_idx = (m_owner >= 0) ? 3'(m_owner) : 3'd0;
      tests++;
      assert (gnt === e_gnt) else begin
         fails++;
         $error("FAIL %s gnt: got %h expected %h", tag, gnt, e_gnt);
      end
      tests++;
      assert (gnt_idx === e_idx) else begin
         fails++;
         $error("FAIL %s gnt_idx: got %0d expected %0d", tag, gnt_idx, e_idx);
      end
      tests++;
      assert (gnt_valid === (m_owner >= 0)) else begin
         fails++;
         $error("FAIL %s gnt_valid: got %b expected %b", tag, gnt_valid, (m_owner >= 0));
      end
      tests++;
      assert (timeout_evt === m_evt) else begin
         fails++;
         $error("FAIL %s timeout_evt: got %b expected %b", tag, timeout_evt, m_evt);
      end
   endtask

   task automatic cyc(input string tag);
      @(posedge clk);
      model_step(req);
      #1;
      check_model(tag);
   endtask

   task automatic apply_reset();
      req   = 8'h00;
      rst_n = 1'b0;
      model_reset();
      repeat (2) @(posedge clk);
      #1;
      check_model("reset");
      rst_n = 1'b1;
   endtask

   initial begin
      int         cnt;
      int         evt_cyc;
      int         order[$];
      logic [7:0] r;

      model_reset();

      // 1: single request, release, pointer advanced past the winner
      apply_reset();
      req = 8'h04; cyc("t1_grant");
      check_val("t1_gnt", 32'(gnt), 32'h04);
      check_val("t1_idx", 32'(gnt_idx), 32'd2);
      req = 8'h00; cyc("t1_turn");
      check_val("t1_turn_gnt", 32'(gnt), 32'h00);
      cyc("t1_idle");
      req = 8'h0C; cyc("t1_ptr3");
      check_val("t1_ptr3_idx", 32'(gnt_idx), 32'd3);

      // 2: alternation between requesters 0 and 7
      apply_reset();
      req = 8'h81; cyc("t2_g0");
      check_val("t2_first_idx", 32'(gnt_idx), 32'd0);
      req = 8'h80; cyc("t2_turn0");
      req = 8'h81; cyc("t2_idle0");
      cyc("t2_g7");
      check_val("t2_second_idx", 32'(gnt_idx), 32'd7);
      req = 8'h01; cyc("t2_turn7");
      req = 8'h81; cyc("t2_idle7");
      cyc("t2_g0b");
      check_val("t2_third_idx", 32'(gnt_idx), 32'd0);

      // 3: all requesting, each grant dropped after one cycle
      apply_reset();
      req = 8'hFF;
      for (int i = 0; i < 60 && order.size() < 9; i++) begin
         cyc("t3_rr");
         if (gnt_valid) order.push_back(int'(gnt_idx));
         req = (m_owner >= 0) ? (8'hFF & ~8'(1 << m_owner)) : 8'hFF;
      end
      check_val("t3_count", 32'(order.size()), 32'd9);
      for (int i = 0; i < order.size(); i++) check_val("t3_order", 32'(order[i]), 32'(i % 8));

      // 4: request held forever -> timeout after exactly MAX_HOLD cycles
      apply_reset();
      req = 8'h10;
      cnt = 0;
      evt_cyc = -1;
      for (int i = 1; i <= 19; i++) begin
         cyc("t4_hold");
         if (i <= 18 && gnt === 8'h10) cnt++;
         if (timeout_evt === 1'b1 && evt_cyc < 0) evt_cyc = i;
         if (i == 18) check_val("t4_gap_gnt", 32'(gnt), 32'h00);
      end
      check_val("t4_hold_len", 32'(cnt), 32'(MAX_HOLD));
      check_val("t4_evt_cycle", 32'(evt_cyc), 32'(MAX_HOLD + 1));
      check_val("t4_regrant", 32'(gnt), 32'h10);

      // 5: asynchronous reset mid-grant
      apply_reset();
      req = 8'h20; cyc("t5_grant");
      repeat (3) cyc("t5_hold");
      #2 rst_n = 1'b0;
      #1;
      model_reset();
      check_val("t5_async_gnt", 32'(gnt), 32'h00);
      check_val("t5_async_valid", 32'(gnt_valid), 32'd0);
      check_model("t5_async");
      @(posedge clk);
      #1 rst_n = 1'b1;
      cyc("t5_regrant");
      check_val("t5_regrant_idx", 32'(gnt_idx), 32'd5);
      req = 8'h00; cyc("t5_turn");
      cyc("t5_idle");
      req = 8'h60; cyc("t5_ptr6");
      check_val("t5_ptr6_idx", 32'(gnt_idx), 32'd6);

      // 6: request drops in the very cycle the hold limit is reached
      apply_reset();
      req = 8'h10;
      repeat (MAX_HOLD) cyc("t6_hold");
      req = 8'h00; cyc("t6_release");
      check_val("t6_evt", 32'(timeout_evt), 32'd0);
      check_val("t6_gnt", 32'(gnt), 32'h00);

      // Random traffic against the model
      apply_reset();
      for (int i = 0; i < 600; i++) begin
         r = req ^ (8'($urandom) & 8'($urandom) & 8'($urandom));
         if (m_owner >= 0 && ($urandom % 4) != 0) r[m_owner] = 1'b1;
         req = r;
         cyc("rand");
         tests++;
         assert ($onehot0(gnt)) else begin
            fails++;
            $error("FAIL rand_onehot: got %h expected one-hot or zero", gnt);
         end
      end

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule

`default_nettype wire
